bin_add_4bit: RTL and testbench

BIN_ADD_4BIT -- requirements
Module: bin_add_4bit

---
 rtl/bin_add_4bit_pkg.sv | 10 +
 rtl/bin_add_4bit_full_adder.sv | 14 +
 rtl/bin_add_4bit.sv | 42 ++++
 tb/tb_bin_add_4bit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bin_add_4bit_pkg.sv
// rtl/bin_add_4bit_pkg.sv - shared width constant and sum type for the ripple-carry adder
`timescale 1ns/1ps
package bin_add_4bit_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Carry-out in the MSB, sum bits below it.
    typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage

// File: rtl/bin_add_4bit_full_adder.sv
// rtl/bin_add_4bit_full_adder.sv - one-bit combinational full adder, one ripple stage
`timescale 1ns/1ps
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bin_add_4bit.sv
// rtl/bin_add_4bit.sv - registered unsigned adder built from a ripple chain of full adders
`timescale 1ns/1ps
module bin_add_4bit
    import bin_add_4bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             COut
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    assign carry[0] = 1'b0;

    // Stage i consumes carry[i] and produces carry[i+1]; carry[WIDTH] is the carry-out.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            COut <= 1'b0;
        end else begin
            S    <= sum_bits;
            COut <= carry[WIDTH];
        end
    end

endmodule

// File: tb/tb_bin_add_4bit.sv
// tb/tb_bin_add_4bit.sv - directed self-checking bench for bin_add_4bit
`timescale 1ns/1ps
module tb_bin_add_4bit;
    import bin_add_4bit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] S;
    logic       COut;

    int tests_run;
    int tests_failed;

    bin_add_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .S     (S),
        .COut  (COut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        A = 4'hF;
        B = 4'hF;
        #1;
        tests_run++;
        if ({COut, S} !== 5'h00) begin
            tests_failed++;
            $display("FAIL reset_immediate: got COut=%b S=%h, want COut=0 S=0", COut, S);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({COut, S} !== 5'h00) begin
                tests_failed++;
                $display("FAIL reset_held: got COut=%b S=%h, want COut=0 S=0", COut, S);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        @(negedge clk);
        A = 4'd7;
        B = 4'd8;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b0, 4'd15}) begin
            tests_failed++;
            $display("FAIL basic_7_8: got COut=%b S=%0d, want COut=0 S=15", COut, S);
        end
        @(negedge clk);
        A = 4'd0;
        B = 4'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL basic_0_0: got COut=%b S=%0d, want COut=0 S=0", COut, S);
        end
        // Unknown operands for one edge, then valid ones must fully recover.
        @(negedge clk);
        A = 4'bxxxx;
        B = 4'bzzzz;
        @(negedge clk);
        A = 4'd5;
        B = 4'd6;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b0, 4'd11}) begin
            tests_failed++;
            $display("FAIL x_recovery: got COut=%b S=%0d, want COut=0 S=11", COut, S);
        end
    endtask

    task automatic test_carry();
        @(negedge clk);
        A = 4'd15;
        B = 4'd1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL carry_15_1: got COut=%b S=%0d, want COut=1 S=0", COut, S);
        end
        @(negedge clk);
        A = 4'd15;
        B = 4'd15;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b1, 4'd14}) begin
            tests_failed++;
            $display("FAIL carry_15_15: got COut=%b S=%0d, want COut=1 S=14", COut, S);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        A = 4'd3;
        B = 4'd4;
        @(posedge clk);
        #2;
        A = 4'd10;
        B = 4'd5;
        #1;
        tests_run++;
        if ({COut, S} !== {1'b0, 4'd7}) begin
            tests_failed++;
            $display("FAIL latency_hold_a: got COut=%b S=%0d, want COut=0 S=7", COut, S);
        end
        #3;
        B = 4'd6;
        #1;
        tests_run++;
        if ({COut, S} !== {1'b0, 4'd7}) begin
            tests_failed++;
            $display("FAIL latency_hold_b: got COut=%b S=%0d, want COut=0 S=7", COut, S);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL latency_update: got COut=%b S=%0d, want COut=1 S=0", COut, S);
        end
    endtask

    task automatic test_back_to_back();
        sum_t exp_sum;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                A = 4'(a);
                B = 4'(b);
                exp_sum = sum_t'(a + b);
                @(posedge clk);
                #1;
                tests_run++;
                if ({COut, S} !== exp_sum) begin
                    tests_failed++;
                    $display("FAIL sweep_%0d_%0d: got %0d, want %0d", a, b, {COut, S}, exp_sum);
                end
            end
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        A = 4'd12;
        B = 4'd9;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b1, 4'd5}) begin
            tests_failed++;
            $display("FAIL midrun_pre: got COut=%b S=%0d, want COut=1 S=5", COut, S);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({COut, S} !== 5'h00) begin
            tests_failed++;
            $display("FAIL midrun_async: got COut=%b S=%0d, want COut=0 S=0", COut, S);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== 5'h00) begin
            tests_failed++;
            $display("FAIL midrun_held: got COut=%b S=%0d, want COut=0 S=0", COut, S);
        end
        #2;
        rst_n = 1'b1;
        A = 4'd9;
        B = 4'd9;
        @(posedge clk);
        #1;
        tests_run++;
        if ({COut, S} !== {1'b1, 4'd2}) begin
            tests_failed++;
            $display("FAIL midrun_release: got COut=%b S=%0d, want COut=1 S=2", COut, S);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_carry();
        test_latency();
        test_back_to_back();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
